// File: rtl/scan_pkg.sv
// Shared types and sizing helpers for the configuration scan-chain loader.
package scan_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} scan_ld_state_t;

  function automatic int unsigned calc_num_words(input int unsigned chain_len,
                                                 input int unsigned data_w);
    return (chain_len + data_w - 1) / data_w;
  endfunction

  function automatic int unsigned calc_last_bits(input int unsigned chain_len,
                                                 input int unsigned data_w);
    return chain_len - (calc_num_words(chain_len, data_w) - 1) * data_w;
  endfunction

  // Width of a counter that must hold the values 0..n inclusive.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/scan_rb_deser.sv
// Packs the bits returning on so into LSB-first readback words; the final
// partial word of a pass is flushed with its upper bits zero.
module scan_rb_deser
  import scan_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cap_en,
  input  logic              so,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int unsigned CW = cnt_w(CHAIN_LEN);
  localparam int unsigned BW = cnt_w(DATA_W);

  logic [DATA_W-1:0] pack;
  logic [DATA_W-1:0] pack_next;
  logic [BW-1:0]     bpos;
  logic [CW-1:0]     ccnt;
  logic              last_cap;
  logic              word_done;

  always_comb begin
    pack_next = pack | (DATA_W'(so) << bpos);
    last_cap  = (ccnt == CW'(CHAIN_LEN - 1));
    word_done = (bpos == BW'(DATA_W - 1)) || last_cap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pack     <= '0;
      bpos     <= '0;
      ccnt     <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (cap_en) begin
        if (word_done) begin
          rb_data  <= pack_next;
          rb_valid <= 1'b1;
          pack     <= '0;
          bpos     <= '0;
        end else begin
          pack <= pack_next;
          bpos <= bpos + 1'b1;
        end
        ccnt <= last_cap ? '0 : ccnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/scan_chain_loader.sv
// Serializes DATA_W-bit config words LSB-first onto the scan chain, one
// CHAIN_LEN-bit pass per start, and repacks the displaced contents.
module scan_chain_loader
  import scan_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              se,
  output logic              si,
  input  logic              so,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NUM_WORDS = calc_num_words(CHAIN_LEN, DATA_W);
  localparam int unsigned CW        = cnt_w(CHAIN_LEN);
  localparam int unsigned AW        = cnt_w(NUM_WORDS);
  localparam int unsigned BW        = cnt_w(DATA_W);

  scan_ld_state_t state, state_d;

  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] hr;
  logic              hr_full;
  logic [CW-1:0]     shift_cnt;
  logic [AW-1:0]     acc_cnt;
  logic [BW-1:0]     bit_idx;

  logic accept;
  logic emit;
  logic last_bit;
  logic word_end;
  logic sr_from_hr;
  logic sr_from_in;
  logic hr_wr;

  assign busy      = (state != IDLE);
  assign cfg_ready = busy && !hr_full && (acc_cnt < AW'(NUM_WORDS));
  assign accept    = cfg_valid && cfg_ready;
  assign last_bit  = (shift_cnt == CW'(CHAIN_LEN - 1));
  assign word_end  = (bit_idx == BW'(DATA_W - 1)) || last_bit;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // A word arriving on the last bit of the current one goes straight into SR
  // so the shift stream continues without a bubble.
  always_comb begin
    state_d    = state;
    emit       = 1'b0;
    sr_from_hr = 1'b0;
    sr_from_in = 1'b0;
    case (state)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        if (hr_full) begin
          sr_from_hr = 1'b1;
          state_d    = SHIFT;
        end else if (accept) begin
          sr_from_in = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        emit = 1'b1;
        if (last_bit)      state_d    = DONE;
        else if (word_end) begin
          if (hr_full)     sr_from_hr = 1'b1;
          else if (accept) sr_from_in = 1'b1;
          else             state_d    = LOAD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    hr_wr = accept && !sr_from_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      se        <= 1'b0;
      si        <= 1'b0;
      done      <= 1'b0;
      sr        <= '0;
      hr        <= '0;
      hr_full   <= 1'b0;
      shift_cnt <= '0;
      acc_cnt   <= '0;
      bit_idx   <= '0;
    end else begin
      done <= (state == DONE);
      se   <= emit;
      if (emit) begin
        si        <= sr[0];
        sr        <= sr >> 1;
        shift_cnt <= shift_cnt + 1'b1;
        bit_idx   <= word_end ? '0 : bit_idx + 1'b1;
      end
      if (state == IDLE && start) begin
        shift_cnt <= '0;
        acc_cnt   <= '0;
        bit_idx   <= '0;
        hr_full   <= 1'b0;
      end else if (accept) begin
        acc_cnt <= acc_cnt + 1'b1;
      end
      if (sr_from_hr)      sr <= hr;
      else if (sr_from_in) sr <= cfg_data;
      if (hr_wr) begin
        hr      <= cfg_data;
        hr_full <= 1'b1;
      end else if (sr_from_hr) begin
        hr_full <= 1'b0;
      end
    end
  end

  scan_rb_deser #(
    .CHAIN_LEN(CHAIN_LEN),
    .DATA_W   (DATA_W)
  ) u_deser (
    .clk     (clk),
    .reset   (reset),
    .cap_en  (se),
    .so      (so),
    .rb_data (rb_data),
    .rb_valid(rb_valid)
  );

endmodule
